// File: rtl/fa_serial_ctrl.sv
// Bit-serial add/subtract controller driving an external 1-bit full-adder slice.
// Operands are shifted LSB-first through the slice; the result assembles MSB-in.
module fa_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             abort,
    output logic             fa_p,
    output logic             fa_g,
    output logic             fa_ci,
    output logic             fa_mode,
    input  logic             fa_sum,
    input  logic             fa_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             run;

    assign run = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                // abort in IDLE suppresses acceptance for that cycle
                if (in_valid && !abort) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    carry_d = fa_co;
                    sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                    a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        ovf_d   = carry_q ^ fa_co;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Slice inputs are gated to zero outside RUN so the slice never toggles idle.
    assign fa_p      = run & (a_sh_q[0] ^ b_sh_q[0]);
    assign fa_g      = run & (a_sh_q[0] & b_sh_q[0]);
    assign fa_ci     = run & carry_q;
    assign fa_mode   = run;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Directed bench for fa_serial_ctrl (WIDTH=8) with a behavioural full-adder slice.
module tb_fa_serial_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             abort = 1'b0;
    logic             fa_p, fa_g, fa_ci, fa_mode;
    logic             fa_sum, fa_co;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // behavioural 1-bit full adder from propagate/generate
    assign fa_sum = fa_p ^ fa_ci;
    assign fa_co  = fa_g | (fa_p & fa_ci);

    fa_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .abort(abort),
        .fa_p(fa_p), .fa_g(fa_g), .fa_ci(fa_ci), .fa_mode(fa_mode),
        .fa_sum(fa_sum), .fa_co(fa_co), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for the result; leaves it in DONE.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                            input logic cv, input logic sv, output int lat);
        @(negedge clk);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h5A; cin = 1'b0; sub = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv,
                          input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        start_op(av, bv, cv, sv, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(WIDTH));
        chk({tag, "_res"}, {out_valid, sum, cout, ovf}, {1'b1, es, ec, eo});
        $display("op %s a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d lat=%0d",
                 tag, av, bv, cv, sv, sum, cout, ovf, lat);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
    endtask

    initial begin
        int lat;
        #12;
        chk("reset_state", {in_ready, out_valid, busy, fa_p, fa_g, fa_ci, fa_mode, sum, cout, ovf},
            {1'b1, 6'b0, 8'h00, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_00c", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub_20_10", 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("sub_05_03c", 8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);

        // backpressure with a stray request that must be ignored
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat);
        chk("bp_lat", 64'(lat), 64'(WIDTH));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h11; b = 8'h22;
            @(posedge clk); #1;
            chk("bp_hold", {out_valid, in_ready, busy, fa_p, fa_g, fa_ci, fa_mode, sum, cout, ovf},
                {1'b1, 1'b0, 1'b1, 4'b0000, 8'h96, 1'b0, 1'b1});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", {in_ready, out_valid}, 2'b10);
        $display("backpressure released sum=%02h", sum);

        // abort at counter=3
        @(negedge clk);
        a = 8'h33; b = 8'h44; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("abort_run", {busy, fa_mode}, 2'b11);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", {in_ready, busy, out_valid, fa_mode}, 4'b1000);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        chk("abort_no_valid", 64'(lat), 64'd0);
        $display("abort at count 3 done");
        run_op("post_abort", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);

        // abort while IDLE blocks acceptance
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h01;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_idle_block", {in_ready, busy}, 2'b10);

        // asynchronous reset mid-RUN
        @(negedge clk);
        a = 8'hC3; b = 8'h3C; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {in_ready, out_valid, busy, fa_p, fa_g, fa_ci, fa_mode, sum, cout, ovf},
            {1'b1, 6'b0, 8'h00, 2'b00});
        $display("async reset mid-run applied");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset", 8'h9C, 8'h64, 1'b0, 1'b1, 8'h38, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
